// File: rtl/washer_pkg.sv
// Shared washer definitions: temperature widths, cold-wash target and the
// heater sequencer state encoding.
package washer_pkg;

  localparam int TEMP_W   = 6;
  localparam int SENSOR_W = 7;

  // A requested temperature of zero means a cold wash: no heating at all.
  localparam logic [TEMP_W-1:0] TEMP_COLD = '0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HEAT     = 2'd1,
    MAINTAIN = 2'd2,
    FAULT    = 2'd3
  } heater_state_t;

endpackage

// File: rtl/heater_timeout_timer.sv
// Heating watchdog: 16-bit cycle counter that flags when it has counted
// LIMIT-1 cycles since the last clear. Used only when HEATER_TIMEOUT_EN
// is defined.
module heater_timeout_timer #(
  parameter int unsigned LIMIT = 6000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [15:0] LAST = 16'(LIMIT - 1);

  logic [15:0] count;

  // Count while enabled; clear has priority so the count restarts at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 16'd1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/water_heater_controller.sv
// Closed-loop heater sequencer: heats the drum water to the latched target,
// then holds it with hysteresis until aborted. Every output is registered.
// Optional macro HEATER_TIMEOUT_EN builds in the heating watchdog and the
// FAULT state; without it, HEAT waits indefinitely and fault stays 0.
//
// Handshake: start is a single-cycle request sampled only in IDLE; abort is
// a level honoured in any non-IDLE state and wins over start and every
// other condition. No ready/acknowledge is returned; busy reflects state.
module water_heater_controller
  import washer_pkg::*;
#(
  parameter int HYST           = 2,
  parameter int TIMEOUT_CYCLES = 6000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [TEMP_W-1:0]   target_temperature,
  input  logic [SENSOR_W-1:0] water_temperature,
  input  logic                sensor_valid,
  output logic                heater_on,
  output logic                temp_reached,
  output logic                reached_pulse,
  output logic                busy,
  output logic                fault
);

  // Reject a timeout that does not fit the 16-bit watchdog.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end

  localparam logic [7:0] HYST8 = 8'(HYST);

  heater_state_t       state, state_n;
  logic [TEMP_W-1:0]   target, target_n;
  logic                heater_n;
  logic                pulse_n;
  logic                timed_out;

  // Latched target widened to sensor width; the hysteresis sum to 8 bits.
  logic [SENSOR_W-1:0] target7;
  logic [7:0]          water_plus_hyst;
  logic                at_target;
  logic                below_band;

  assign target7         = {1'b0, target};
  assign water_plus_hyst = {1'b0, water_temperature} + HYST8;
  assign at_target       = water_temperature >= target7;
  assign below_band      = water_plus_hyst <= {2'b00, target};

`ifdef HEATER_TIMEOUT_EN
  logic timer_expired;

  // Counter restarts whenever we are outside HEAT, so it reads zero on the
  // first HEAT cycle and FAULT lands exactly TIMEOUT_CYCLES edges after entry.
  heater_timeout_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (state != HEAT),
    .enable (state == HEAT),
    .expired(timer_expired)
  );

  assign timed_out = timer_expired;
`else
  assign timed_out = 1'b0;
`endif

  // Next state, latched target and next heater drive.
  always_comb begin
    state_n  = state;
    target_n = target;
    heater_n = heater_on;
    pulse_n  = 1'b0;
    case (state)
      IDLE: begin
        heater_n = 1'b0;
        if (start && !abort) begin
          target_n = target_temperature;
          if (target_temperature == TEMP_COLD) begin
            state_n = MAINTAIN;
          end else begin
            state_n  = HEAT;
            heater_n = 1'b1;
          end
        end
      end
      HEAT: begin
        heater_n = 1'b1;
        // Reaching the target beats a same-cycle timeout.
        if (sensor_valid && at_target) begin
          state_n  = MAINTAIN;
          heater_n = 1'b0;
          pulse_n  = 1'b1;
        end else if (timed_out) begin
          state_n  = FAULT;
          heater_n = 1'b0;
        end
      end
      MAINTAIN: begin
        if (sensor_valid) begin
          if (at_target) begin
            heater_n = 1'b0;
          end else if (below_band) begin
            heater_n = 1'b1;
          end
        end
      end
      FAULT: begin
        heater_n = 1'b0;
      end
      default: begin
        state_n  = IDLE;
        heater_n = 1'b0;
      end
    endcase
    if (abort && state != IDLE) begin
      state_n  = IDLE;
      heater_n = 1'b0;
      pulse_n  = 1'b0;
    end
  end

  // State, target and all outputs share one register stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      target        <= '0;
      heater_on     <= 1'b0;
      temp_reached  <= 1'b0;
      reached_pulse <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_n;
      target        <= target_n;
      heater_on     <= heater_n;
      temp_reached  <= (state_n == MAINTAIN);
      reached_pulse <= pulse_n;
      busy          <= (state_n != IDLE);
    end
  end

`ifdef HEATER_TIMEOUT_EN
  // Fault flag mirrors residency in FAULT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fault <= 1'b0;
    end else begin
      fault <= (state_n == FAULT);
    end
  end
`else
  assign fault = 1'b0;
`endif

endmodule
